// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register carrying an opaque control and data vector.
// An optional two-entry skid buffer lets in_ready_o be a register-only function.
module pipe_stage_reg #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 128,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CTRL_W-1:0] head_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_xfer;
  logic              out_xfer;
  logic              head_from_in;
  logic              head_from_skid;
  logic              skid_load;

  // With the skid buffer, readiness depends only on stored occupancy.
  assign in_ready_o  = SKID_EN ? (start_i && (state != TWO))
                               : (start_i && ((state == EMPTY) || out_ready_i));
  assign out_valid_o = start_i && (state != EMPTY);
  assign in_xfer     = in_valid_i && in_ready_o;
  assign out_xfer    = out_valid_o && out_ready_i;
  assign out_ctrl_o  = out_valid_o ? head_ctrl : '0;
  assign out_data_o  = head_data;
  assign occ_o       = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_nxt      = state;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            head_from_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_from_in = 1'b1;
          end else if (in_xfer && SKID_EN) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            head_from_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: data registers are reset too, because out_data_o must read zero out of reset.
    if (rst_i) begin
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      // Only control is scrubbed on flush; stale data is harmless once invalid.
      head_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (head_from_in) begin
        head_ctrl <= in_ctrl_i;
        head_data <= in_data_i;
      end else if (head_from_skid) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end
      if (skid_load) begin
        skid_ctrl <= in_ctrl_i;
        skid_data <= in_data_i;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a skid and a non-skid instance with shared inputs
// and checks both against a small queue model every cycle, plus literal scenario checks.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          rdy  [2];
  logic          vld  [2];
  logic [CW-1:0] octl [2];
  logic [DW-1:0] odat [2];
  logic [1:0]    occ  [2];

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(vld[0]), .out_ready_i(out_ready), .out_ctrl_o(octl[0]),
    .out_data_o(odat[0]), .occ_o(occ[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(vld[1]), .out_ready_i(out_ready), .out_ctrl_o(octl[1]),
    .out_data_o(odat[1]), .occ_o(occ[1])
  );

  // Model: index 0 = single register (capacity 1), index 1 = skid (capacity 2).
  // Entry 0 of each queue is the head; m_last is what the head register last held.
  logic [CW-1:0] m_ctrl [2][2];
  logic [DW-1:0] m_data [2][2];
  int            m_cnt  [2] = '{0, 0};
  logic [DW-1:0] m_last [2] = '{'0, '0};

  function automatic logic e_ready(int i);
    if (i == 1) return start && (m_cnt[i] < 2);
    return start && ((m_cnt[i] == 0) || out_ready);
  endfunction

  function automatic logic e_valid(int i);
    return start && (m_cnt[i] > 0);
  endfunction

  function automatic logic [CW-1:0] e_ctrl(int i);
    return e_valid(i) ? m_ctrl[i][0] : '0;
  endfunction

  function automatic logic [DW-1:0] e_data(int i);
    return (m_cnt[i] > 0) ? m_data[i][0] : m_last[i];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update at each edge (or asynchronously on reset).
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        logic it;
        logic ot;
        if (rst) begin
          m_cnt[i]  = 0;
          m_last[i] = '0;
        end else if (flush) begin
          m_cnt[i] = 0;
        end else begin
          it = e_ready(i) && in_valid;
          ot = e_valid(i) && out_ready;
          if (ot) begin
            m_ctrl[i][0] = m_ctrl[i][1];
            m_data[i][0] = m_data[i][1];
            m_cnt[i]--;
          end
          if (it) begin
            m_ctrl[i][m_cnt[i]] = in_ctrl;
            m_data[i][m_cnt[i]] = in_data;
            m_cnt[i]++;
          end
          if (m_cnt[i] > 0) m_last[i] = m_data[i][0];
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs of both instances.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_in_ready", i), DW'(rdy[i]), DW'(e_ready(i)));
        check($sformatf("m%0d_out_valid", i), DW'(vld[i]), DW'(e_valid(i)));
        check($sformatf("m%0d_out_ctrl", i), DW'(octl[i]), DW'(e_ctrl(i)));
        check($sformatf("m%0d_out_data", i), odat[i], e_data(i));
        check($sformatf("m%0d_occ", i), DW'(occ[i]), DW'(m_cnt[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    logic acc;

    // Reset state, sampled between edges while reset is held.
    #12;
    check("rst_occ", DW'(occ[1]), 0);
    check("rst_valid", DW'(vld[1]), 0);
    check("rst_ctrl", DW'(octl[1]), 0);
    check("rst_data", odat[1], 0);
    check("rst_ready", DW'(rdy[1]), 1);
    rst = 1'b0;
    tick();

    // Stream 1..5 with downstream always ready: one-cycle latency, no gaps.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_ctrl = CW'(k);
      in_data = DW'(k);
      tick();
      check("stream_data", odat[1], DW'(k));
      check("stream_ctrl", DW'(octl[1]), DW'(k));
      check("stream_occ", DW'(occ[1]), 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", DW'(occ[1]), 0);

    // Backpressure: 10 accepted, 11 absorbed by skid, 12 stalls upstream.
    in_valid = 1'b1; in_ctrl = 8'd10; in_data = 10;
    tick();
    out_ready = 1'b0; in_ctrl = 8'd11; in_data = 11;
    tick();
    check("bp_occ2", DW'(occ[1]), 2);
    check("bp_ready_low", DW'(rdy[1]), 0);
    check("bp_head", odat[1], 10);
    in_ctrl = 8'd12; in_data = 12;
    tick();
    tick();
    check("bp_hold", odat[1], 10);
    out_ready = 1'b1;
    tick();
    check("bp_second", odat[1], 11);
    check("bp_ready_back", DW'(rdy[1]), 1);
    tick();
    check("bp_third", odat[1], 12);
    in_valid = 1'b0;
    tick();
    check("bp_drain", DW'(occ[1]), 0);

    // Flush while full, with a new input offered: everything dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'd20; in_data = 20;
    tick();
    in_ctrl = 8'd21; in_data = 21;
    tick();
    check("fl_full", DW'(occ[1]), 2);
    flush = 1'b1; out_ready = 1'b1; in_ctrl = 8'd22; in_data = 22;
    tick();
    check("fl_occ", DW'(occ[1]), 0);
    check("fl_valid", DW'(vld[1]), 0);
    check("fl_ctrl", DW'(octl[1]), 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_no22", DW'(vld[1]), 0);

    // Freeze with one entry held.
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'd30; in_data = 30;
    tick();
    start = 1'b0; out_ready = 1'b1; in_ctrl = 8'd31; in_data = 31;
    repeat (4) begin
      tick();
      check("fz_valid", DW'(vld[1]), 0);
      check("fz_ready", DW'(rdy[1]), 0);
      check("fz_occ", DW'(occ[1]), 1);
    end
    start = 1'b1; in_valid = 1'b0;
    #1;
    check("fz_resume_valid", DW'(vld[1]), 1);
    check("fz_resume_data", odat[1], 30);
    tick();
    check("fz_once", DW'(vld[1]), 0);

    // Single-register mode: ready follows downstream ready while occupied.
    d = 40;
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = CW'(d); in_data = DW'(d);
    tick();
    d++;
    for (int j = 0; j < 4; j++) begin
      out_ready = (j % 2 == 0);
      in_ctrl   = CW'(d);
      in_data   = DW'(d);
      #1;
      check("s0_ready_mirror", DW'(rdy[0]), DW'(out_ready));
      check("s0_occ", DW'(occ[0]), 1);
      acc = rdy[0];
      tick();
      if (acc) d++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("s0_drain", DW'(occ[0]), 0);

    // Reset mid-stream while full.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'd48; in_data = 48;
    tick();
    in_ctrl = 8'd49; in_data = 49;
    tick();
    check("rm_full", DW'(occ[1]), 2);
    rst = 1'b1;
    #1;
    check("rm_occ", DW'(occ[1]), 0);
    check("rm_valid", DW'(vld[1]), 0);
    check("rm_ctrl", DW'(octl[1]), 0);
    check("rm_data", odat[1], 0);
    rst = 1'b0;
    #1;
    out_ready = 1'b1; in_ctrl = 8'd50; in_data = 50;
    tick();
    check("rm_next_valid", DW'(vld[1]), 1);
    check("rm_next_data", odat[1], 50);

    // Randomised traffic; the compare process does the checking.
    repeat (400) begin
      start     = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    start = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
